// File: rtl/button_debounce_edge_pkg.sv
// Shared constants for the manual clock/step button path.
// Holds the debounce FSM state encoding and the default timing constants
// used by the top-level manual-step path.
package button_debounce_edge_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    // Default timing for the manual-step key
    localparam int unsigned DEF_SYNC_STAGES     = 2;
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
    localparam int unsigned DEF_CNT_W           = 5;

    // Both wait states have bit 0 set.
    function automatic logic is_wait_state(input logic [1:0] st);
        return st[0];
    endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Reusable N-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk       - destination clock
//   count_rst - asynchronous, active-high reset (all flops load RESET_VAL)
//   i_d       - asynchronous input bit
//   o_q       - synchronized output, STAGES clk edges behind i_d
module sync_ff_chain
    import button_debounce_edge_pkg::*;
#(
    parameter int unsigned STAGES    = DEF_SYNC_STAGES,
    parameter bit          RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic count_rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or posedge count_rst) begin
        if (count_rst) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/button_debounce_edge.sv
// Push-button conditioner for the manual clock/step key.
// Synchronizes the raw key, debounces it with a 4-state FSM and counter, and
// produces a clean level plus one-cycle press/release strobes. rise is the
// trigger for the downstream pulse-stretching monostable.
// Ports:
//   clk       - system clock
//   count_rst - asynchronous, active-high reset
//   btn_in    - raw asynchronous button
//   level     - debounced pressed state (1 = pressed)
//   rise      - one-clk strobe on accepted press
//   fall      - one-clk strobe on accepted release
//   busy      - high while a change is being debounced
// All outputs are registered; nothing combinational from btn_in.
module button_debounce_edge
    import button_debounce_edge_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = DEF_CNT_W,
    parameter bit          ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic count_rst,
    input  logic btn_in,
    output logic level,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_sync_raw;
    logic             w_s;
    logic [1:0]       r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_level, r_rise, r_fall, r_busy;
    logic             w_level_d, w_rise_d, w_fall_d, w_busy_d;

    // Reset to the idle raw level so reset never looks like a press.
    sync_ff_chain #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk       (clk),
        .count_rst (count_rst),
        .i_d       (btn_in),
        .o_q       (w_sync_raw)
    );

    // Polarity correction after the synchronizer: 1 = pressed.
    assign w_s = w_sync_raw ^ ACTIVE_LOW;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_rise_d  = 1'b0;
        w_fall_d  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_s) begin
                    w_state_d = ST_PRESS_WAIT;
                    w_cnt_d   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!w_s) begin
                    w_state_d = ST_IDLE;
                    w_cnt_d   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_d = ST_PRESSED;
                    w_cnt_d   = '0;
                    w_rise_d  = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!w_s) begin
                    w_state_d = ST_RELEASE_WAIT;
                    w_cnt_d   = '0;
                end
            end
            ST_RELEASE_WAIT: begin
                if (w_s) begin
                    w_state_d = ST_PRESSED;
                    w_cnt_d   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_d = ST_IDLE;
                    w_cnt_d   = '0;
                    w_fall_d  = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_cnt_d   = '0;
            end
        endcase
    end

    // Level stays high through RELEASE_WAIT until the release is accepted.
    assign w_level_d = (w_state_d == ST_PRESSED) || (w_state_d == ST_RELEASE_WAIT);
    assign w_busy_d  = is_wait_state(w_state_d);

    always_ff @(posedge clk or posedge count_rst) begin
        if (count_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_level <= w_level_d;
            r_rise  <= w_rise_d;
            r_fall  <= w_fall_d;
            r_busy  <= w_busy_d;
        end
    end

    assign level = r_level;
    assign rise  = r_rise;
    assign fall  = r_fall;
    assign busy  = r_busy;

endmodule

// File: tb/tb_button_debounce_edge.sv
module tb_button_debounce_edge;

    localparam int S  = 2;
    localparam int D0 = 16;
    localparam int D1 = 4;

    logic clk = 1'b0;
    logic count_rst = 1'b1;
    logic btn0 = 1'b0;   // active-high key
    logic btn1 = 1'b1;   // active-low key, released
    logic level0, rise0, fall0, busy0;
    logic level1, rise1, fall1, busy1;

    always #5 clk = ~clk;

    button_debounce_edge u_dut0 (
        .clk       (clk),
        .count_rst (count_rst),
        .btn_in    (btn0),
        .level     (level0),
        .rise      (rise0),
        .fall      (fall0),
        .busy      (busy0)
    );

    button_debounce_edge #(
        .SYNC_STAGES     (S),
        .DEBOUNCE_CYCLES (D1),
        .CNT_W           (5),
        .ACTIVE_LOW      (1'b1)
    ) u_dut1 (
        .clk       (clk),
        .count_rst (count_rst),
        .btn_in    (btn1),
        .level     (level1),
        .rise      (rise1),
        .fall      (fall1),
        .busy      (busy1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit is_rise;
    } ev_t;

    ev_t q0[$];
    ev_t q1[$];
    ev_t e0, e1;
    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, exp, cyc);
    endtask

    task automatic expect0(input int at, input bit r);
        ev_t e;
        e.cyc = at;
        e.is_rise = r;
        q0.push_back(e);
    endtask

    task automatic expect1(input int at, input bit r);
        ev_t e;
        e.cyc = at;
        e.is_rise = r;
        q1.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard monitors: every strobe must match the head of its queue.
    always @(negedge clk) begin
        if (rise0 || fall0) begin
            check("dut0_not_both", int'(rise0 & fall0), 0);
            if (q0.size() == 0) begin
                n_chk++;
                $display("FAIL dut0_unexpected_strobe: got rise=%0d fall=%0d at cyc %0d, required none",
                         rise0, fall0, cyc);
            end else begin
                e0 = q0.pop_front();
                check("dut0_strobe_cycle", cyc, e0.cyc);
                check("dut0_strobe_is_rise", int'(rise0), int'(e0.is_rise));
            end
        end else if (q0.size() > 0 && q0[0].cyc <= cyc) begin
            e0 = q0.pop_front();
            n_chk++;
            $display("FAIL dut0_missing_strobe: got none at cyc %0d, required %s at cyc %0d",
                     cyc, e0.is_rise ? "rise" : "fall", e0.cyc);
        end
    end

    always @(negedge clk) begin
        if (rise1 || fall1) begin
            check("dut1_not_both", int'(rise1 & fall1), 0);
            if (q1.size() == 0) begin
                n_chk++;
                $display("FAIL dut1_unexpected_strobe: got rise=%0d fall=%0d at cyc %0d, required none",
                         rise1, fall1, cyc);
            end else begin
                e1 = q1.pop_front();
                check("dut1_strobe_cycle", cyc, e1.cyc);
                check("dut1_strobe_is_rise", int'(rise1), int'(e1.is_rise));
            end
        end else if (q1.size() > 0 && q1[0].cyc <= cyc) begin
            e1 = q1.pop_front();
            n_chk++;
            $display("FAIL dut1_missing_strobe: got none at cyc %0d, required %s at cyc %0d",
                     cyc, e1.is_rise ? "rise" : "fall", e1.cyc);
        end
    end

    initial begin
        int n;
        #1;
        check("rst_level0", int'(level0), 0);
        check("rst_rise0", int'(rise0), 0);
        check("rst_fall0", int'(fall0), 0);
        check("rst_busy0", int'(busy0), 0);
        check("rst_level1", int'(level1), 0);
        check("rst_busy1", int'(busy1), 0);
        step(3);
        count_rst = 1'b0;
        step(5);

        // Clean press held 100 cycles: one rise after edge 18, busy on edges 3..18.
        n = cyc;
        btn0 = 1'b1;
        expect0(n + 1 + S + D0, 1'b1);
        for (int m = 1; m <= 100; m++) begin
            step(1);
            check("t1_busy", int'(busy0), int'(m >= 3 && m <= 18));
            check("t1_level", int'(level0), int'(m >= 19));
        end

        // 5-cycle release glitch: level holds, no strobe.
        btn0 = 1'b0;
        step(5);
        btn0 = 1'b1;
        for (int m = 1; m <= 30; m++) begin
            step(1);
            check("t3_glitch_level", int'(level0), 1);
        end

        // Real release held 40 cycles.
        n = cyc;
        btn0 = 1'b0;
        expect0(n + 1 + S + D0, 1'b0);
        for (int m = 1; m <= 40; m++) begin
            step(1);
            check("t3_rel_level", int'(level0), int'(m < 19));
            check("t3_rel_busy", int'(busy0), int'(m >= 3 && m <= 18));
        end

        // Bouncing press 1,0,1 (3-cycle widths) then stable.
        btn0 = 1'b1;
        step(3);
        btn0 = 1'b0;
        step(3);
        n = cyc;
        btn0 = 1'b1;
        expect0(n + 1 + S + D0, 1'b1);
        for (int m = 1; m <= 60; m++) begin
            step(1);
            check("t2_level", int'(level0), int'(m >= 19));
        end
        n = cyc;
        btn0 = 1'b0;
        expect0(n + 1 + S + D0, 1'b0);
        step(40);
        check("t2_released", int'(level0), 0);

        // Reset while in PRESS_WAIT with cnt=10, key still held.
        n = cyc;
        btn0 = 1'b1;
        step(13);
        check("t5_busy_pre_rst", int'(busy0), 1);
        count_rst = 1'b1;
        #1;
        check("t5_rst_level", int'(level0), 0);
        check("t5_rst_busy", int'(busy0), 0);
        check("t5_rst_rise", int'(rise0), 0);
        check("t5_rst_fall", int'(fall0), 0);
        @(negedge clk);
        count_rst = 1'b0;
        n = cyc;
        expect0(n + 1 + S + D0, 1'b1);
        step(40);
        check("t5_level_after", int'(level0), 1);
        n = cyc;
        btn0 = 1'b0;
        expect0(n + 1 + S + D0, 1'b0);
        step(40);

        // Back-to-back clean presses spaced 50 cycles.
        for (int k = 0; k < 3; k++) begin
            n = cyc;
            btn0 = 1'b1;
            expect0(n + 1 + S + D0, 1'b1);
            step(25);
            check("t6_pressed", int'(level0), 1);
            n = cyc;
            btn0 = 1'b0;
            expect0(n + 1 + S + D0, 1'b0);
            step(25);
            check("t6_released", int'(level0), 0);
        end

        // Active-low key, 4-cycle debounce: rise after edge 6.
        n = cyc;
        btn1 = 1'b0;
        expect1(n + 1 + S + D1, 1'b1);
        for (int m = 1; m <= 12; m++) begin
            step(1);
            check("t4_level", int'(level1), int'(m >= 7));
            check("t4_busy", int'(busy1), int'(m >= 3 && m <= 6));
        end
        n = cyc;
        btn1 = 1'b1;
        expect1(n + 1 + S + D1, 1'b0);
        step(12);
        check("t4_released", int'(level1), 0);

        step(5);
        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/button_debounce_edge.md
Name: button_debounce_edge

Overview:
- Conditions a raw, bouncing push-button (single-step / manual-trigger key) into clean, clk-synchronous signals.
- Its one-cycle `rise` output is the trigger source for the downstream pulse-stretching monostable stage in the processor's manual clock/step path.
- Contains a synchronizer, a debounce counter and a 4-state FSM. Also provides the debounced level and a release strobe.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops on btn_in; legal values 2..4.
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required to accept a change; legal values 2..2^CNT_W.
- CNT_W, 5: debounce counter width.
- ACTIVE_LOW, 0: 1 = button reads 0 when pressed; input is inverted after synchronization.

Ports:
- clk  input  1  system clock.
- count_rst  input  1  asynchronous, active-high reset.
- btn_in  input  1  raw asynchronous button.
- level  output  1  debounced pressed state (1 = pressed).
- rise  output  1  one-clk strobe on accepted press; drives the monostable trigger.
- fall  output  1  one-clk strobe on accepted release.
- busy  output  1  high while in PRESS_WAIT or RELEASE_WAIT.

Behaviour:
- Interface: reset count_rst, asynchronous, active-high; clock clk.
- All flops are reset asynchronously by count_rst.
- Reset values:
  - level=0, rise=0, fall=0, busy=0.
  - State = IDLE, counter = 0.
  - Synchronizer flops = inactive raw level (ACTIVE_LOW).
- s = synchronizer output, polarity-corrected (1 = pressed). s lags btn_in by SYNC_STAGES edges.
- All outputs are registered; there are no combinational paths from btn_in.
- FSM states and transitions:
  - IDLE (level=0): s=1 -> PRESS_WAIT, cnt<=0; otherwise hold.
  - PRESS_WAIT:
    - s=0 -> IDLE, cnt<=0. This is a bounce; no strobe.
    - s=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED; level<=1, rise<=1.
    - Otherwise cnt<=cnt+1.
  - PRESSED (level=1): s=0 -> RELEASE_WAIT, cnt<=0; otherwise hold.
  - RELEASE_WAIT:
    - s=1 -> PRESSED, cnt<=0; level stays 1, no strobe.
    - s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; level<=0, fall<=1.
    - Otherwise cnt<=cnt+1.
- rise and fall are high for exactly one cycle, and never both in the same cycle.
- Latency: edge 0 is the first clk edge at which btn_in is held pressed. rise and level go high immediately after edge SYNC_STAGES+DEBOUNCE_CYCLES (edge 18 at defaults). Release latency is symmetric for fall.
- Counter:
  - Unsigned, compared only against DEBOUNCE_CYCLES-1, so it never wraps.
  - Cleared on every state entry.
- Holding the button indefinitely gives exactly one rise; there is no auto-repeat.
- A glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no level change and no strobe, in either direction.
- Reset mid-operation:
  - All outputs drop immediately; an in-flight rise/fall is lost.
  - After count_rst deasserts with the button held, a full press debounce runs and rise fires once.
- busy = (state==PRESS_WAIT or state==RELEASE_WAIT), registered with the state.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3).
  - Default constants for DEBOUNCE_CYCLES and SYNC_STAGES, used by the top-level manual-step path.
- One sub-module, sync_ff_chain (parameters STAGES, RESET_VAL). It is a reusable N-flop synchronizer with async reset to RESET_VAL.
- The FSM and counter stay in button_debounce_edge.

Test Plan:
- Defaults; btn_in 0->1 held 100 cycles -> rise=1 for exactly one cycle after edge 18, level=1 from then on, busy=1 during edges 3..18, fall never.
- Press with bounces (btn_in toggles 1,0,1 with 3-cycle widths, then stable 1) -> no rise during bounces; single rise 18 edges after the last 0->1 change.
- Held press, then release held 40 cycles -> fall one cycle after edge 18 of release, level=0; a 5-cycle release glitch before that -> level stays 1, no fall, no rise.
- ACTIVE_LOW=1, DEBOUNCE_CYCLES=4; btn_in 1->0 held -> rise after edge 6, level=1.
- count_rst pulsed while in PRESS_WAIT at cnt=10, btn still held -> outputs 0 immediately; after deassert, rise fires once at edge 18 counted from the first post-reset edge.
- Back-to-back clean presses spaced 50 cycles -> one rise and one fall per press, never simultaneous.
